// File: rtl/segre_pkg.sv
// Shared core definitions: datapath word width and the dcache refill FSM states.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    RD_WAIT,
    FILL,
    DONE
  } dcache_refill_state_e;

endpackage

// File: rtl/segre_line_buffer.sv
// Lane assembly register: WORDS x WIDTH words, one word written per cycle by index.
module segre_line_buffer
  import segre_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned WIDTH = WORD_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rsn_i,
  input  logic                       we_i,
  input  logic [$clog2(WORDS)-1:0]   idx_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WORDS*WIDTH-1:0]     data_o
);

  logic [WIDTH-1:0] r_words [WORDS];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        r_words[i] <= '0;
      end
    end else if (we_i) begin
      r_words[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      data_o[i*WIDTH +: WIDTH] = r_words[i];
    end
  end

endmodule

// File: rtl/segre_dcache_refill.sv
// Dcache miss/refill controller: optional dirty-victim writeback, word-beat lane fetch,
// then a single full-lane fill strobe into the data array.
module segre_dcache_refill
  import segre_pkg::*;
#(
  parameter  int unsigned NUM_LANES      = 4,
  parameter  int unsigned BYTES_PER_LANE = 16,
  localparam int unsigned WORDS_PER_LANE = BYTES_PER_LANE / (WORD_SIZE / 8),
  localparam int unsigned LANE_SIZE      = WORD_SIZE * WORDS_PER_LANE,
  localparam int unsigned INDEX_BITS     = $clog2(NUM_LANES),
  localparam int unsigned LANE_OFF_BITS  = $clog2(BYTES_PER_LANE),
  localparam int unsigned TAG_SIZE       = WORD_SIZE - INDEX_BITS - LANE_OFF_BITS
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 miss_i,
  input  logic [WORD_SIZE-1:0] miss_addr_i,
  input  logic                 victim_dirty_i,
  input  logic [TAG_SIZE-1:0]  victim_tag_i,
  input  logic [LANE_SIZE-1:0] victim_data_i,
  output logic                 busy_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  output logic                 fill_o,
  output logic [WORD_SIZE-1:0] fill_addr_o,
  output logic [LANE_SIZE-1:0] fill_data_o,
  output logic                 done_o
);

  localparam int unsigned WORD_OFF_BITS = $clog2(WORD_SIZE / 8);
  localparam int unsigned CNT_BITS      = $clog2(WORDS_PER_LANE);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(WORDS_PER_LANE - 1);
  localparam logic [CNT_BITS:0]   RSP_FULL  = (CNT_BITS + 1)'(WORDS_PER_LANE);
  localparam logic [CNT_BITS:0]   RSP_LAST  = (CNT_BITS + 1)'(WORDS_PER_LANE - 1);
  localparam logic [WORD_SIZE-1:0] LANE_MASK =
    {{(WORD_SIZE - LANE_OFF_BITS){1'b1}}, {LANE_OFF_BITS{1'b0}}};

  dcache_refill_state_e r_state, w_state_nxt;

  logic [WORD_SIZE-1:0] r_line_addr;
  logic [TAG_SIZE-1:0]  r_victim_tag;
  logic [LANE_SIZE-1:0] r_victim_data;
  logic [CNT_BITS-1:0]  r_req_cnt;
  logic [CNT_BITS:0]    r_rsp_cnt;

  logic                 w_latch;
  logic                 w_cnt_clr;
  logic                 w_req_adv;
  logic                 w_rsp_take;
  logic [LANE_SIZE-1:0] w_buf_data;
  logic [WORD_SIZE-1:0] w_wb_addr;
  logic [WORD_SIZE-1:0] w_rd_addr;
  logic [WORD_SIZE-1:0] w_victim_words [WORDS_PER_LANE];

  always_comb begin
    for (int unsigned i = 0; i < WORDS_PER_LANE; i++) begin
      w_victim_words[i] = r_victim_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Beat offsets wrap inside the lane because the counter is exactly the word-index width.
  assign w_wb_addr = {r_victim_tag, r_line_addr[LANE_OFF_BITS +: INDEX_BITS],
                      r_req_cnt, {WORD_OFF_BITS{1'b0}}};
  assign w_rd_addr = {r_line_addr[WORD_SIZE-1:LANE_OFF_BITS],
                      r_req_cnt, {WORD_OFF_BITS{1'b0}}};

  assign w_rsp_take = ((r_state == RD) || (r_state == RD_WAIT)) &&
                      mem_rvalid_i && (r_rsp_cnt < RSP_FULL);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    fill_o      = 1'b0;
    fill_addr_o = '0;
    fill_data_o = '0;
    done_o      = 1'b0;
    w_latch     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_req_adv   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (miss_i) begin
          w_latch     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = victim_dirty_i ? WB : RD;
        end
      end
      WB: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_wb_addr;
        mem_wdata_o = w_victim_words[r_req_cnt];
        if (mem_gnt_i) begin
          if (r_req_cnt == LAST_BEAT) begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = RD;
          end else begin
            w_req_adv = 1'b1;
          end
        end
      end
      RD: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = w_rd_addr;
        if (mem_gnt_i) begin
          w_req_adv = 1'b1;
          if (r_req_cnt == LAST_BEAT) begin
            w_state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        busy_o = 1'b1;
        if ((r_rsp_cnt == RSP_FULL) || (w_rsp_take && (r_rsp_cnt == RSP_LAST))) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        busy_o      = 1'b1;
        fill_o      = 1'b1;
        fill_addr_o = r_line_addr;
        fill_data_o = w_buf_data;
        w_state_nxt = DONE;
      end
      DONE: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_line_addr   <= '0;
      r_victim_tag  <= '0;
      r_victim_data <= '0;
    end else if (w_latch) begin
      r_line_addr   <= miss_addr_i & LANE_MASK;
      r_victim_tag  <= victim_tag_i;
      r_victim_data <= victim_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_req_adv) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
      if (w_rsp_take) begin
        r_rsp_cnt <= r_rsp_cnt + 1'b1;
      end
    end
  end

  segre_line_buffer #(
    .WORDS (WORDS_PER_LANE),
    .WIDTH (WORD_SIZE)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .we_i    (w_rsp_take),
    .idx_i   (r_rsp_cnt[CNT_BITS-1:0]),
    .wdata_i (mem_rdata_i),
    .data_o  (w_buf_data)
  );

endmodule

// File: tb/tb_segre_dcache_refill.sv
// Scoreboard bench for segre_dcache_refill: memory model with in-order delayed responses,
// expected beats/fills queued at miss issue and checked by a negedge monitor.
module tb_segre_dcache_refill;
  import segre_pkg::*;

  localparam int unsigned WPL    = 4;
  localparam int unsigned LANE_W = WORD_SIZE * WPL;

  logic                 clk = 1'b0;
  logic                 rsn_i;
  logic                 miss_i;
  logic [31:0]          miss_addr_i;
  logic                 victim_dirty_i;
  logic [25:0]          victim_tag_i;
  logic [LANE_W-1:0]    victim_data_i;
  logic                 busy_o, mem_req_o, mem_we_o;
  logic [31:0]          mem_addr_o, mem_wdata_o;
  logic                 mem_gnt_i, mem_rvalid_i;
  logic [31:0]          mem_rdata_i;
  logic                 fill_o, done_o;
  logic [31:0]          fill_addr_o;
  logic [LANE_W-1:0]    fill_data_o;

  always #5 clk = ~clk;

  segre_dcache_refill #(
    .NUM_LANES      (4),
    .BYTES_PER_LANE (16)
  ) dut (
    .clk_i          (clk),
    .rsn_i          (rsn_i),
    .miss_i         (miss_i),
    .miss_addr_i    (miss_addr_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_tag_i   (victim_tag_i),
    .victim_data_i  (victim_data_i),
    .busy_o         (busy_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .fill_o         (fill_o),
    .fill_addr_o    (fill_addr_o),
    .fill_data_o    (fill_data_o),
    .done_o         (done_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] addr; logic [LANE_W-1:0] data; }     fill_t;
  typedef struct { int unsigned due; logic [31:0] data; }            rsp_t;

  beat_t exp_beats[$];
  fill_t exp_fills[$];
  rsp_t  pend[$];
  logic [31:0] mem [logic [31:0]];

  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0;
  int unsigned gnt_mode = 0, lat_min = 1, lat_max = 1;
  int unsigned stall_beat = 0, stall_left = 0, rd_acc = 0;
  int unsigned last_due = 0, rsp_n = 0, rsp4_cyc = 0, fill_cyc = 0;
  int unsigned n_fills = 0, n_done = 0, done_target = 0;
  int unsigned exp_fill_cyc = 0, exp_first_req = 0;
  bit          stray = 0, rv_stray = 0;
  bit          hold_v = 0, hold_we = 0;
  logic [31:0] hold_addr = '0, hold_wdata = '0;

  task automatic chk(input string name, input logic [LANE_W-1:0] act, input logic [LANE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory model: one in-order response per cycle once its due cycle arrives.
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      rv_stray = 1'b0;
      if (!rsn_i) begin
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
      end else begin
        if (stray) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; rv_stray = 1'b1;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = pend[0].data; void'(pend.pop_front());
        end else begin
          mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        end
        case (gnt_mode)
          0: mem_gnt_i = 1'b1;
          1: mem_gnt_i = ($urandom_range(3) != 0);
          default: begin
            if (mem_req_o && !mem_we_o && rd_acc == stall_beat && stall_left > 0) begin
              mem_gnt_i = 1'b0; stall_left--;
            end else begin
              mem_gnt_i = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Monitor/scoreboard.
  initial begin
    beat_t e; fill_t f; int unsigned due;
    forever begin
      @(negedge clk);
      if (!rsn_i) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall_req", mem_req_o, 1'b1);
          chk("stall_addr", mem_addr_o, hold_addr);
          chk("stall_we", mem_we_o, hold_we);
          chk("stall_wdata", mem_wdata_o, hold_wdata);
        end
        hold_v = mem_req_o && !mem_gnt_i;
        hold_addr = mem_addr_o; hold_we = mem_we_o; hold_wdata = mem_wdata_o;
        if (mem_req_o && exp_first_req != 0) begin
          chk("first_req_cycle", cyc, exp_first_req);
          exp_first_req = 0;
        end
        if (mem_req_o && mem_gnt_i) begin
          if (exp_beats.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got addr %h we %0b want no request", mem_addr_o, mem_we_o);
          end else begin
            e = exp_beats.pop_front();
            chk("beat_we", mem_we_o, e.we);
            chk("beat_addr", mem_addr_o, e.addr);
            if (e.we) chk("beat_wdata", mem_wdata_o, e.data);
          end
          if (!mem_we_o) begin
            rd_acc++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{due, mem_rd(mem_addr_o)});
          end
        end
        if (mem_rvalid_i && !rv_stray) begin
          rsp_n++;
          if (rsp_n == WPL) rsp4_cyc = cyc;
        end
        if (fill_o) begin
          if (exp_fills.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_fill: got addr %h want no fill", fill_addr_o);
          end else begin
            f = exp_fills.pop_front();
            chk("fill_addr", fill_addr_o, f.addr);
            chk("fill_data", fill_data_o, f.data);
          end
          chk("fill_after_last_rsp", cyc, rsp4_cyc + 1);
          if (exp_fill_cyc != 0) begin
            chk("fill_cycle", cyc, exp_fill_cyc);
            exp_fill_cyc = 0;
          end
          fill_cyc = cyc; rsp_n = 0; rd_acc = 0; n_fills++;
        end
        if (done_o) begin
          chk("done_cycle", cyc, fill_cyc + 1);
          chk("done_busy", busy_o, 1'b1);
          n_done++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Reference: writeback beats at {victim tag, miss index, offset}, then lane reads.
  task automatic push_exp(input logic [31:0] addr, input bit dirty,
                          input logic [31:0] vaddr, input logic [LANE_W-1:0] vdata);
    logic [31:0] line, wb_base, w;
    logic [LANE_W-1:0] lane;
    line    = addr & 32'hFFFF_FFF0;
    wb_base = (vaddr & 32'hFFFF_FFC0) | (addr & 32'h0000_0030);
    if (dirty) begin
      for (int unsigned b = 0; b < WPL; b++) begin
        w = vdata[b*32 +: 32];
        exp_beats.push_back('{1'b1, wb_base + 4*b, w});
        mem[wb_base + 4*b] = w;
      end
    end
    lane = '0;
    for (int unsigned b = 0; b < WPL; b++) begin
      exp_beats.push_back('{1'b0, line + 4*b, 32'h0});
      lane[b*32 +: 32] = mem_rd(line + 4*b);
    end
    exp_fills.push_back('{line, lane});
    done_target++;
  endtask

  task automatic issue(input logic [31:0] addr, input bit dirty,
                       input logic [31:0] vaddr, input logic [LANE_W-1:0] vdata);
    push_exp(addr, dirty, vaddr, vdata);
    miss_i = 1'b1; miss_addr_i = addr; victim_dirty_i = dirty;
    victim_tag_i = vaddr[31:6]; victim_data_i = vdata;
    step();
    miss_i = 1'b0; victim_dirty_i = $urandom_range(1);
    miss_addr_i = $urandom; victim_data_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (n_done < done_target && n < 400) begin step(); n++; end
    if (n_done < done_target) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d done pulses want %0d", n_done, done_target);
      done_target = n_done;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_req"}, mem_req_o, 1'b0);
    chk({tag, "_we"}, mem_we_o, 1'b0);
    chk({tag, "_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, "_fill"}, fill_o, 1'b0);
    chk({tag, "_fill_addr"}, fill_addr_o, 32'h0);
    chk({tag, "_fill_data"}, fill_data_o, '0);
    chk({tag, "_done"}, done_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int unsigned n, saved_f, saved_d;
    logic [31:0] a, va;
    rsn_i = 1'b0; miss_i = 1'b0; miss_addr_i = '0; victim_dirty_i = 1'b0;
    victim_tag_i = '0; victim_data_i = '0;
    #12;
    check_zero("reset");
    @(posedge clk); #2; rsn_i = 1'b1;
    step(); step();

    // Clean miss, gnt high, 1-cycle responses.
    for (int unsigned b = 0; b < WPL; b++) mem[32'h1230 + 4*b] = 32'hA0 + b;
    exp_fill_cyc = cyc + 6; exp_first_req = cyc + 1;
    issue(32'h0000_1234, 1'b0, 32'h0, '0);
    wait_done();
    step();

    // Dirty miss: four writebacks add four cycles.
    exp_fill_cyc = cyc + 10; exp_first_req = cyc + 1;
    issue(32'h0000_1234, 1'b1, 32'h0000_5230,
          {32'hDDDD_00D3, 32'hDDDD_00D2, 32'hDDDD_00D1, 32'hDDDD_00D0});
    wait_done();

    // Read beat 1 stalled 3 cycles, responses 4 cycles late.
    gnt_mode = 2; stall_beat = 1; stall_left = 3; rd_acc = 0; lat_min = 4; lat_max = 4;
    issue(32'h0000_8A48, 1'b0, 32'h0, '0);
    wait_done();
    gnt_mode = 0; lat_min = 1; lat_max = 1;

    // Stray rvalid in idle, then miss held high across a whole refill.
    stray = 1'b1; step(); step(); stray = 1'b0; step(); step();
    push_exp(32'h0000_3C18, 1'b0, 32'h0, '0);
    exp_fill_cyc = cyc + 6;
    miss_i = 1'b1; miss_addr_i = 32'h0000_3C18; victim_dirty_i = 1'b0;
    n = 0;
    while (!done_o && n < 100) begin step(); n++; end
    if (!done_o) begin
      total++; bad++;
      $display("FAIL held_miss_timeout: got no done want done pulse");
    end
    step();
    push_exp(32'h0000_44E0, 1'b0, 32'h0, '0);
    miss_addr_i = 32'h0000_44E0; exp_first_req = cyc + 1;
    step();
    miss_i = 1'b0;
    wait_done();

    // Asynchronous reset mid-RD after two responses.
    lat_min = 2; lat_max = 2;
    issue(32'h0000_7A5C, 1'b0, 32'h0, '0);
    n = 0;
    while (rsp_n < 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("abort_rsp_seen", rsp_n, 2);
    chk("abort_in_rd", mem_req_o, 1'b1);
    saved_f = n_fills; saved_d = n_done;
    rsn_i = 1'b0;
    #1;
    check_zero("abort");
    exp_beats.delete(); exp_fills.delete(); pend.delete();
    rsp_n = 0; rd_acc = 0; done_target = n_done;
    step(); step();
    rsn_i = 1'b1;
    repeat (10) step();
    chk("abort_no_fill", n_fills, saved_f);
    chk("abort_no_done", n_done, saved_d);
    lat_min = 1; lat_max = 1;
    exp_fill_cyc = cyc + 6;
    issue(32'h0000_7A5C, 1'b0, 32'h0, '0);
    wait_done();

    // Randomized misses with random gnt and response latency.
    gnt_mode = 1; lat_min = 1; lat_max = 4;
    repeat (24) begin
      a = $urandom; va = $urandom;
      issue(a, $urandom_range(1), va, {$urandom, $urandom, $urandom, $urandom});
      wait_done();
      repeat ($urandom_range(2)) step();
    end

    repeat (5) step();
    chk("beats_left", exp_beats.size(), 0);
    chk("fills_left", exp_fills.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
